fetch_controller: RTL
=====================

Name: fetch_controller

Overview:
Sequences the fetch-stage PC register. Each cycle it chooses the PC source (sequential, predicted, EX-resolved sequential, EX-resolved target) and the fetch stall. It also flushes the decode register on a redirect. An FSM handles instruction-cache misses and aborts an outstanding miss when an EX redirect arrives mid-miss.

Parameters:
MISS_TIMEOUT, 255, max cycles in MISS_WAIT before timeout_o pulses (8-bit counter; 0 disables)

Ports:
clk_i  input  1  clock
reset_i  input  1  reset, asynchronous, active-high
pred_taken_fi_i  input  1  predictor says fetched instr is taken branch/jump
mispredict_ex_i  input  1  EX branch resolved opposite to prediction (single-cycle valid)
branch_taken_ex_i  input  1  actual EX outcome; qualifies mispredict_ex_i
hazard_stall_fi_i  input  1  hazard unit fetch stall
ic_miss_i  input  1  icache miss on current PC
ic_ready_i  input  1  icache refill done / abort acknowledged (1-cycle pulse)
pc_src_o  output  2  to fetch PC mux, PC_SRC_* macro encoding
stall_fi_o  output  1  PC register hold
flush_de_o  output  1  flush F/D pipeline register
ic_abort_o  output  1  cancel outstanding refill (1-cycle pulse)
timeout_o  output  1  miss timeout pulse
busy_o  output  1  FSM not in RUN

Behaviour:
- Reset (async): state=RUN, pc_src_o=PC_SRC_SEQ_F, stall_fi_o=0, flush_de_o=0, ic_abort_o=0, timeout_o=0, busy_o=0, miss counter=0.
- pc_src_o is combinational from current inputs and state:
  - Priority 1, mispredict_ex_i: branch_taken_ex_i=1 gives TARGET_E; 0 gives SEQ_E.
  - Priority 2, pred_taken_fi_i: PRED_F.
  - Otherwise: SEQ_F.
- Redirect (mispredict_ex_i=1) overrides hazard_stall_fi_i and ic_miss_i in the same cycle:
  - stall_fi_o=0 so the PC loads the redirect.
  - flush_de_o=1 for exactly that cycle.
- States:
  - RUN:
    - stall_fi_o = hazard_stall_fi_i | ic_miss_i, unless a redirect is present.
    - ic_miss_i=1 with no redirect: go to MISS_WAIT and clear the counter.
  - MISS_WAIT:
    - stall_fi_o=1, counter increments each cycle.
    - ic_ready_i=1: go to RUN; stall drops in the following cycle.
    - mispredict_ex_i=1: stall_fi_o=0 that cycle, flush_de_o=1, ic_abort_o=1, go to ABORT.
    - counter==MISS_TIMEOUT (nonzero): timeout_o pulses once; stay in MISS_WAIT.
  - ABORT:
    - stall_fi_o=1, waits for ic_ready_i (abort ack), then goes to RUN.
    - A further mispredict here is impossible, because the pipeline behind fetch is drained. Any such mispredict is ignored, except that flush_de_o=1 still applies.
- Simultaneous events:
  - ic_ready_i and mispredict_ex_i in the same MISS_WAIT cycle: the refill completes. Go to RUN and apply the redirect with no abort.
  - ic_ready_i in RUN is ignored.
- Counter saturates at 255.
- Reset asserted mid-miss forces RUN immediately. ic_abort_o is not emitted; the cache resets on the same reset.
- busy_o=1 in MISS_WAIT and ABORT.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- When defined, the block adds two 32-bit saturating counters and output ports perf_redirects_o and perf_miss_cycles_o:
  - perf_redirects_o counts cycles with mispredict_ex_i=1.
  - perf_miss_cycles_o counts cycles in MISS_WAIT or ABORT.
  - Both counters clear on reset.
- When undefined, these ports and registers are absent and all other behaviour is identical.

Decomposition:
- Shared package fetch_ctrl_pkg holds:
  - the state enum fetch_ctrl_state_t {RUN, MISS_WAIT, ABORT};
  - the default MISS_TIMEOUT constant.
- PC_SRC_* encodings remain in control_macros.sv.
- One natural sub-module, miss_timer: an 8-bit saturating counter with clear, enable and compare-equal output.

Test Plan:
- Reset mid-MISS_WAIT at cycle 5 -> busy_o=0, pc_src_o=PC_SRC_SEQ_F, stall_fi_o=0 immediately (asynchronous).
- RUN, pred_taken_fi_i=1, no stalls -> pc_src_o=PC_SRC_PRED_F, stall_fi_o=0. Then mispredict_ex_i=1 with branch_taken_ex_i=0 -> PC_SRC_SEQ_E, flush_de_o=1 for 1 cycle.
- hazard_stall_fi_i=1 and mispredict_ex_i=1 with branch_taken_ex_i=1 in the same cycle -> stall_fi_o=0, pc_src_o=PC_SRC_TARGET_E, flush_de_o=1.
- ic_miss_i=1, then ic_ready_i after 6 cycles -> stall_fi_o=1 for 7 cycles, busy_o=1 for 6 cycles, back in RUN, timeout_o never asserted.
- In MISS_WAIT at cycle 3, mispredict_ex_i=1 -> ic_abort_o=1 and flush_de_o=1 for 1 cycle, stall_fi_o=0 that cycle. Then ABORT with stall_fi_o=1 until ic_ready_i, then RUN.
- MISS_TIMEOUT=4 and no ic_ready_i for 10 cycles -> exactly one timeout_o pulse, on the 5th MISS_WAIT cycle. With FETCH_CTRL_PERF_EN defined, perf_miss_cycles_o=10.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC sequencing controller.
// Holds the miss FSM state encoding and the default miss timeout.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_WAIT = 2'd1,
    ABORT     = 2'd2
  } fetch_ctrl_state_t;

  localparam logic [7:0] MISS_TIMEOUT_DEFAULT = 8'd255;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/control_macros.sv
// Pipeline-wide control encodings shared by the fetch PC mux and its controller.
`ifndef CONTROL_MACROS_SV
`define CONTROL_MACROS_SV

`define PC_SRC_SEQ_F    2'd0
`define PC_SRC_PRED_F   2'd1
`define PC_SRC_SEQ_E    2'd2
`define PC_SRC_TARGET_E 2'd3

`endif

// File: rtl/miss_timer.sv
// 8-bit saturating cycle counter used to time instruction-cache misses.
// Clear wins over enable; match reports equality with the compare value.
module miss_timer (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] cmp_value,
  output logic       match
);

  logic [7:0] count;

  // Counter holds at 255 so a stuck miss cannot wrap back to a match.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign match = (count == cmp_value);

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage PC source / stall sequencer with an icache-miss FSM (RUN, MISS_WAIT, ABORT).
// Define FETCH_CTRL_PERF_EN to add redirect and miss-cycle performance counters.
`ifndef CONTROL_MACROS_SV
`include "control_macros.sv"
`endif

module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter logic [7:0] MISS_TIMEOUT = MISS_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pred_taken_fi_i,
  input  logic        mispredict_ex_i,
  input  logic        branch_taken_ex_i,
  input  logic        hazard_stall_fi_i,
  input  logic        ic_miss_i,
  input  logic        ic_ready_i,
  output logic [1:0]  pc_src_o,
  output logic        stall_fi_o,
  output logic        flush_de_o,
  output logic        ic_abort_o,
  output logic        timeout_o,
  output logic        busy_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_redirects_o,
  output logic [31:0] perf_miss_cycles_o
`endif
);

  fetch_ctrl_state_t state, next_state;
  logic busy_q;
  logic timeout_done;
  logic timer_clear;
  logic timer_match;
  logic timeout_hit;
  logic [1:0] pc_src;
  logic stall, flush, abort;

  miss_timer u_miss_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear     (timer_clear),
    .enable    (state == MISS_WAIT),
    .cmp_value (MISS_TIMEOUT),
    .match     (timer_match)
  );

  // A redirect from EX always wins: the PC must load it, so stall is dropped that cycle.
  always_comb begin
    next_state  = state;
    timer_clear = 1'b0;
    stall       = 1'b0;
    abort       = 1'b0;
    flush       = mispredict_ex_i;

    if (mispredict_ex_i) begin
      pc_src = branch_taken_ex_i ? `PC_SRC_TARGET_E : `PC_SRC_SEQ_E;
    end else if (pred_taken_fi_i) begin
      pc_src = `PC_SRC_PRED_F;
    end else begin
      pc_src = `PC_SRC_SEQ_F;
    end

    case (state)
      RUN: begin
        stall = !mispredict_ex_i && (hazard_stall_fi_i || ic_miss_i);
        if (ic_miss_i && !mispredict_ex_i) begin
          next_state  = MISS_WAIT;
          timer_clear = 1'b1;
        end
      end
      MISS_WAIT: begin
        if (ic_ready_i) begin
          stall      = !mispredict_ex_i;
          next_state = RUN;
        end else if (mispredict_ex_i) begin
          abort      = 1'b1;
          next_state = ABORT;
        end else begin
          stall = 1'b1;
        end
      end
      ABORT: begin
        stall = 1'b1;
        if (ic_ready_i) begin
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  // Timeout fires once per miss; the sticky flag stops repeats once the counter saturates.
  assign timeout_hit = (state == MISS_WAIT) && (MISS_TIMEOUT != 8'd0)
                       && timer_match && !timeout_done;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= RUN;
      busy_q       <= 1'b0;
      timeout_done <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != RUN);
      if (timer_clear) begin
        timeout_done <= 1'b0;
      end else if (timeout_hit) begin
        timeout_done <= 1'b1;
      end
    end
  end

  // While reset is held the outputs show their idle values regardless of inputs.
  assign pc_src_o   = reset_i ? `PC_SRC_SEQ_F : pc_src;
  assign stall_fi_o = stall && !reset_i;
  assign flush_de_o = flush && !reset_i;
  assign ic_abort_o = abort && !reset_i;
  assign timeout_o  = timeout_hit && !reset_i;
  assign busy_o     = busy_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_redirects_q, perf_miss_cycles_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_redirects_q   <= 32'd0;
      perf_miss_cycles_q <= 32'd0;
    end else begin
      if (mispredict_ex_i) begin
        perf_redirects_q <= sat_inc32(perf_redirects_q);
      end
      if (state != RUN) begin
        perf_miss_cycles_q <= sat_inc32(perf_miss_cycles_q);
      end
    end
  end

  assign perf_redirects_o   = perf_redirects_q;
  assign perf_miss_cycles_o = perf_miss_cycles_q;
`endif

endmodule
